// File: rtl/mesa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesa_pkg
// Brief    : Shared Mesa framing constants and packet-tracker state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mesa_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam logic [7:0] MESA_SOP  = 8'hF0;
    localparam logic [7:0] MESA_IDLE = 8'hFF;

    localparam int MESA_HDR_BYTES = 4;

endpackage : mesa_pkg
`default_nettype wire

// File: rtl/mesa_pkt_track.sv
`default_nettype none
// ============================================================================
// Module   : mesa_pkt_track
// Brief    : Nibble-to-byte assembly, header index and payload down-count for
//            the granted Mesa nibble stream; pulses pkt_done/hdr_len_valid.
// Revision : 1.0 - initial release
// ============================================================================
module mesa_pkt_track (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       clr,
    input  logic       nib_vld,
    input  logic [3:0] nib,
    output logic       pkt_done,
    output logic       hdr_len_valid
);
    import mesa_pkg::*;

    localparam logic [1:0] c_hdr_last = 2'(MESA_HDR_BYTES - 1);

    logic [1:0] r_state;
    logic       r_phase;
    logic [1:0] r_idx;
    logic [3:0] r_hi;
    logic [7:0] r_pay_cnt;

    logic [1:0] w_state;
    logic       w_phase;
    logic [1:0] w_idx;
    logic [7:0] w_byte;

    // A release clears the tracker so a nibble in the same cycle starts fresh.
    always_comb begin
        w_state = clr ? ST_IDLE : r_state;
        w_phase = clr ? 1'b0 : r_phase;
        w_idx   = clr ? 2'd0 : r_idx;
        w_byte  = {r_hi, nib};
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state       <= ST_IDLE;
            r_phase       <= 1'b0;
            r_idx         <= 2'd0;
            r_hi          <= 4'h0;
            r_pay_cnt     <= 8'h00;
            pkt_done      <= 1'b0;
            hdr_len_valid <= 1'b0;
        end else begin
            pkt_done      <= 1'b0;
            hdr_len_valid <= 1'b0;
            r_state       <= w_state;
            r_phase       <= w_phase;
            r_idx         <= w_idx;
            if (nib_vld) begin
                if (!w_phase) begin
                    r_hi    <= nib;
                    r_phase <= 1'b1;
                    if (w_state == ST_IDLE) begin
                        r_state <= ST_HDR;
                    end
                end else begin
                    r_phase <= 1'b0;
                    if (w_state == ST_PAYLOAD) begin
                        if (r_pay_cnt == 8'd1) begin
                            pkt_done <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_pay_cnt <= r_pay_cnt - 8'd1;
                        end
                    end else if (w_idx == 2'd0 && w_byte != MESA_SOP) begin
                        pkt_done <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_idx    <= 2'd0;
                    end else if (w_idx == c_hdr_last) begin
                        hdr_len_valid <= 1'b1;
                        r_idx         <= 2'd0;
                        if (w_byte == 8'h00) begin
                            pkt_done <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_pay_cnt <= w_byte;
                            r_state   <= ST_PAYLOAD;
                        end
                    end else begin
                        r_idx <= w_idx + 2'd1;
                    end
                end
            end
        end
    end

endmodule : mesa_pkt_track
`default_nettype wire

// File: rtl/mesa_nib_arb.sv
`default_nettype none
// ============================================================================
// Module   : mesa_nib_arb
// Brief    : Per-packet arbiter sharing the Mesa nibble decoder between UART
//            (src0) and SPI (src1); steers lb_rd_rdy back to the requester.
//            Optional: MESA_NIB_ARB_DROP_CNT_EN builds the dropped-nibble count.
// Revision : 1.0 - initial release
// ============================================================================
module mesa_nib_arb #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TMR_W       = 11
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic [3:0] nib0_d,
    input  logic       nib0_rdy,
    input  logic [3:0] nib1_d,
    input  logic       nib1_rdy,
    input  logic       lb_rd_rdy,
    output logic [3:0] nib_d,
    output logic       nib_rdy,
    output logic       rd_rdy0,
    output logic       rd_rdy1,
    output logic [1:0] owner,
    output logic [7:0] drop_cnt
);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]       r_owner;
    logic             r_rr_last;
    logic             r_rd_owner;
    logic [TMR_W-1:0] r_tmr;

    logic w_pkt_done;
    logic w_hdr_len_valid;
    logic w_owner_nib;
    logic w_timeout;
    logic w_release;
    logic w_free;
    logic w_rr_eff;
    logic w_gnt0;
    logic w_gnt1;
    logic w_fwd;

    assign w_owner_nib = (r_owner[0] & nib0_rdy) | (r_owner[1] & nib1_rdy);
    assign w_timeout   = (r_owner != 2'b00) & ~w_owner_nib & (r_tmr == c_tmr_last);
    assign w_release   = w_pkt_done | w_timeout;
    assign w_free      = (r_owner == 2'b00) | w_release;
    // During a release cycle the tie-break already sees the departing owner.
    assign w_rr_eff    = w_release ? r_owner[1] : r_rr_last;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_free) begin
            w_gnt0 = nib0_rdy & (~nib1_rdy | w_rr_eff);
            w_gnt1 = nib1_rdy & (~nib0_rdy | ~w_rr_eff);
        end else begin
            w_gnt0 = r_owner[0] & nib0_rdy;
            w_gnt1 = r_owner[1] & nib1_rdy;
        end
    end

    assign w_fwd = w_gnt0 | w_gnt1;
    assign owner = r_owner;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_owner    <= 2'b00;
            r_rr_last  <= 1'b1;
            r_rd_owner <= 1'b0;
            r_tmr      <= '0;
            nib_d      <= 4'h0;
            nib_rdy    <= 1'b0;
            rd_rdy0    <= 1'b0;
            rd_rdy1    <= 1'b0;
        end else begin
            nib_rdy <= w_fwd;
            if (w_fwd) begin
                nib_d <= w_gnt1 ? nib1_d : nib0_d;
            end
            if (w_free && w_fwd) begin
                r_owner <= {w_gnt1, w_gnt0};
            end else if (w_release) begin
                r_owner <= 2'b00;
            end
            if (w_release) begin
                r_rr_last <= r_owner[1];
            end
            if (r_owner != 2'b00 && !w_fwd && !w_release) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end else begin
                r_tmr <= '0;
            end
            if (w_hdr_len_valid) begin
                r_rd_owner <= r_owner[1];
            end
            rd_rdy0 <= lb_rd_rdy & ~r_rd_owner;
            rd_rdy1 <= lb_rd_rdy & r_rd_owner;
        end
    end

    mesa_pkt_track u_pkt_track (
        .clk           (clk),
        .reset_l       (reset_l),
        .clr           (w_release),
        .nib_vld       (w_fwd),
        .nib           (w_gnt1 ? nib1_d : nib0_d),
        .pkt_done      (w_pkt_done),
        .hdr_len_valid (w_hdr_len_valid)
    );

`ifdef MESA_NIB_ARB_DROP_CNT_EN
    logic w_drop;

    assign w_drop = w_free ? (nib0_rdy & nib1_rdy)
                           : ((r_owner[0] & nib1_rdy) | (r_owner[1] & nib0_rdy));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            drop_cnt <= 8'h00;
        end else if (w_drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = 8'h00;
`endif

endmodule : mesa_nib_arb
`default_nettype wire

// File: tb/tb_mesa_nib_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesa_nib_arb
// Brief    : Directed self-checking bench for mesa_nib_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesa_nib_arb;

    logic       clk;
    logic       reset_l;
    logic [3:0] nib0_d;
    logic       nib0_rdy;
    logic [3:0] nib1_d;
    logic       nib1_rdy;
    logic       lb_rd_rdy;
    logic [3:0] nib_d;
    logic       nib_rdy;
    logic       rd_rdy0;
    logic       rd_rdy1;
    logic [1:0] owner;
    logic [7:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int drops  = 0;

    mesa_nib_arb #(.TIMEOUT_CYC(1024), .TMR_W(11)) u_dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .nib0_d    (nib0_d),
        .nib0_rdy  (nib0_rdy),
        .nib1_d    (nib1_d),
        .nib1_rdy  (nib1_rdy),
        .lb_rd_rdy (lb_rd_rdy),
        .nib_d     (nib_d),
        .nib_rdy   (nib_rdy),
        .rd_rdy0   (rd_rdy0),
        .rd_rdy1   (rd_rdy1),
        .owner     (owner),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef MESA_NIB_ARB_DROP_CNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0;
`endif
    endfunction

    // One clock with the given strobes; returns #1 after the edge.
    task automatic cyc(input logic v0, input logic [3:0] d0,
                       input logic v1, input logic [3:0] d1, input logic lb);
        nib0_rdy  = v0;
        nib0_d    = d0;
        nib1_rdy  = v1;
        nib1_d    = d1;
        lb_rd_rdy = lb;
        @(posedge clk);
        #1;
        nib0_rdy  = 1'b0;
        nib1_rdy  = 1'b0;
        lb_rd_rdy = 1'b0;
    endtask

    task automatic fwd_chk(input string tag, input logic [3:0] d, input logic [1:0] own);
        chk({tag, "_rdy"}, int'(nib_rdy), 1);
        chk({tag, "_d"}, int'(nib_d), int'(d));
        chk({tag, "_own"}, int'(owner), int'(own));
    endtask

    logic [3:0] pkt_a [16] = '{4'hF, 4'h0, 4'hF, 4'hE, 4'h3, 4'h4, 4'h0, 4'h4,
                               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] pkt_z [8]  = '{4'hF, 4'h0, 4'hF, 4'hE, 4'h3, 4'h4, 4'h0, 4'h0};

    initial begin
        reset_l   = 1'b0;
        nib0_d    = 4'h0;
        nib0_rdy  = 1'b0;
        nib1_d    = 4'h0;
        nib1_rdy  = 1'b0;
        lb_rd_rdy = 1'b0;
        #2;
        chk("rst_nib_d", int'(nib_d), 0);
        chk("rst_nib_rdy", int'(nib_rdy), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_rd", int'({rd_rdy1, rd_rdy0}), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        #10 reset_l = 1'b1;
        @(posedge clk);
        #1;

        // Reset-time tie goes to src0; src1 strobes mid-packet are discarded.
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 9 || i == 11) begin
                cyc(1'b1, pkt_a[i], 1'b1, 4'h5, 1'b0);
                drops++;
            end else begin
                cyc(1'b1, pkt_a[i], 1'b0, 4'h0, 1'b0);
            end
            fwd_chk($sformatf("pktA%0d", i), pkt_a[i], 2'b01);
            if (i == 12) begin
                cyc(1'b0, 4'h0, 1'b1, 4'h9, 1'b0);
                drops++;
                chk("pktA_nonowner_rdy", int'(nib_rdy), 0);
                chk("pktA_nonowner_own", int'(owner), 1);
            end
        end
        chk("pktA_drop", int'(drop_cnt), exp_drop());
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("pktA_release_own", int'(owner), 0);
        chk("pktA_release_rdy", int'(nib_rdy), 0);

        // Second tie after src0 released: round-robin hands it to src1.
        cyc(1'b1, 4'h3, 1'b1, pkt_z[0], 1'b0);
        drops++;
        fwd_chk("tie2", pkt_z[0], 2'b10);
        chk("tie2_drop", int'(drop_cnt), exp_drop());
        for (int i = 1; i < 8; i++) begin
            // Read-ready alongside byte3 still steers to the previous requester.
            cyc(1'b0, 4'h0, 1'b1, pkt_z[i], (i == 7) ? 1'b1 : 1'b0);
            fwd_chk($sformatf("pktZ%0d", i), pkt_z[i], 2'b10);
        end
        chk("pktZ_rd_old0", int'(rd_rdy0), 1);
        chk("pktZ_rd_old1", int'(rd_rdy1), 0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("pktZ_release_own", int'(owner), 0);
        chk("pktZ_rd_pulse", int'(rd_rdy0), 0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        chk("pktZ_rd1", int'(rd_rdy1), 1);
        chk("pktZ_rd0", int'(rd_rdy0), 0);

        // src1 goes silent after three nibbles; ownership times out.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 1'b1, pkt_z[i], 1'b0);
            fwd_chk($sformatf("to%0d", i), pkt_z[i], 2'b10);
        end
        for (int i = 0; i < 1023; i++) begin
            cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        end
        chk("to_before", int'(owner), 2);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("to_after", int'(owner), 0);
        chk("to_no_nib", int'(nib_rdy), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, pkt_z[i], 1'b0, 4'h0, 1'b0);
            fwd_chk($sformatf("postto%0d", i), pkt_z[i], 2'b01);
        end
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("postto_release", int'(owner), 0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        chk("postto_rd0", int'(rd_rdy0), 1);
        chk("postto_rd1", int'(rd_rdy1), 0);

        // Async reset in the middle of a payload.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, (i < 8) ? pkt_a[i] : 4'hA + 4'(i - 8), 1'b0, 4'h0, 1'b0);
        end
        chk("pre_rst_nib_d", int'(nib_d), 'hB);
        #2 reset_l = 1'b0;
        #1;
        chk("mid_rst_nib_d", int'(nib_d), 0);
        chk("mid_rst_owner", int'(owner), 0);
        chk("mid_rst_rdy", int'(nib_rdy), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        #3 reset_l = 1'b1;
        drops = 0;
        @(posedge clk);
        #1;
        cyc(1'b1, 4'hF, 1'b1, 4'h7, 1'b0);
        drops++;
        fwd_chk("post_rst_tie", 4'hF, 2'b01);
        chk("post_rst_drop", int'(drop_cnt), exp_drop());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mesa_nib_arb
`default_nettype wire
